// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared state/select encodings and default sizes for the
// VRAM arbiter.
package vram_arb_pkg;

  localparam int DEF_ADDR_W       = 32'd16;
  localparam int DEF_DATA_W       = 32'd16;
  localparam int DEF_MAX_DISP_RUN = 32'd8;

  // Bus cycle currently being driven onto the SRAM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2
  } arb_state_t;

  // Which requester owns the current ACCESS cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DISP = 2'd1,
    SEL_MPU  = 2'd2
  } req_sel_t;

  // SRAM strobes are active-low; keeps the polarity flip in one place.
  function automatic logic strobe_n(input logic active);
    return ~active;
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-cycle SRAM port between a display line
// fetcher (fixed priority, reads only) and an MPU (reads and writes).
// Every clock edge is an arbitration point; a grant becomes a one-cycle
// ACCESS on the following cycle. A read followed directly by a write gets
// one TURN cycle so the pad never drives against the SRAM output.
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to force an MPU grant
// after MAX_DISP_RUN consecutive display grants while the MPU is waiting.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_DISP_RUN = DEF_MAX_DISP_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rdata_valid,
  input  logic              mpu_req,
  input  logic              mpu_wr,
  input  logic [ADDR_W-1:0] mpu_addr,
  input  logic [1:0]        _mpu_be,
  input  logic [DATA_W-1:0] mpu_wdata,
  output logic              mpu_ack,
  output logic [DATA_W-1:0] mpu_rdata,
  output logic              mpu_rdata_valid,
  output logic              _vram_en,
  output logic              _vram_rd,
  output logic              _vram_wr,
  output logic [1:0]        _vram_be,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data_out,
  output logic              vram_data_oe,
  input  logic [DATA_W-1:0] vram_data_in
);

  arb_state_t state_r, state_nxt;
  req_sel_t   sel_r, sel_nxt;
  logic       rd_r, rd_nxt;
  req_sel_t   win_s;
  logic       starve_force_s;
  logic       access_nxt_s;
  logic       cap_disp_s;
  logic       cap_mpu_s;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_DISP_RUN + 32'sd1);
  logic [RUN_W-1:0] run_r;

  assign starve_force_s = mpu_req && (run_r >= RUN_W'(MAX_DISP_RUN));

  // Count display grants made while the MPU waits; any MPU grant or an idle MPU clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r <= '0;
    end else if (!mpu_req || (access_nxt_s && sel_nxt == SEL_MPU)) begin
      run_r <= '0;
    end else if (access_nxt_s && sel_nxt == SEL_DISP) begin
      run_r <= run_r + RUN_W'(1);
    end else begin
      run_r <= run_r;
    end
  end
`else
  assign starve_force_s = 1'b0;
`endif

  assign access_nxt_s = (state_nxt == ST_ACCESS);
  assign cap_disp_s   = (state_r == ST_ACCESS) && (sel_r == SEL_DISP) && rd_r;
  assign cap_mpu_s    = (state_r == ST_ACCESS) && (sel_r == SEL_MPU) && rd_r;

  // Pick the winner for the coming cycle: display first unless the guard forces the MPU
  always_comb begin
    win_s = SEL_NONE;
    if (disp_req && !starve_force_s) begin
      win_s = SEL_DISP;
    end else if (mpu_req) begin
      win_s = SEL_MPU;
    end else begin
      win_s = SEL_NONE;
    end
  end

  // Next bus cycle: ACCESS for the winner, TURN when a write follows a read directly
  always_comb begin
    state_nxt = ST_IDLE;
    sel_nxt   = SEL_NONE;
    rd_nxt    = 1'b0;
    case (win_s)
      SEL_DISP: begin
        state_nxt = ST_ACCESS;
        sel_nxt   = SEL_DISP;
        rd_nxt    = 1'b1;
      end
      SEL_MPU: begin
        if (mpu_wr && (state_r == ST_ACCESS) && rd_r) begin
          state_nxt = ST_TURN;
          sel_nxt   = SEL_NONE;
          rd_nxt    = 1'b0;
        end else begin
          state_nxt = ST_ACCESS;
          sel_nxt   = SEL_MPU;
          rd_nxt    = ~mpu_wr;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        sel_nxt   = SEL_NONE;
        rd_nxt    = 1'b0;
      end
    endcase
  end

  // FSM state, current owner and direction of the cycle on the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sel_r   <= SEL_NONE;
      rd_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      sel_r   <= sel_nxt;
      rd_r    <= rd_nxt;
    end
  end

  // Registered SRAM strobes, address, write data and acks for the cycle being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_ack      <= 1'b0;
      mpu_ack       <= 1'b0;
      _vram_en      <= 1'b1;
      _vram_rd      <= 1'b1;
      _vram_wr      <= 1'b1;
      _vram_be      <= 2'b11;
      vram_addr     <= '0;
      vram_data_out <= '0;
      vram_data_oe  <= 1'b0;
    end else begin
      disp_ack     <= access_nxt_s && (sel_nxt == SEL_DISP);
      mpu_ack      <= access_nxt_s && (sel_nxt == SEL_MPU);
      _vram_en     <= strobe_n(access_nxt_s);
      _vram_rd     <= strobe_n(access_nxt_s && rd_nxt);
      _vram_wr     <= strobe_n(access_nxt_s && !rd_nxt);
      vram_data_oe <= access_nxt_s && !rd_nxt;
      case (sel_nxt)
        SEL_DISP: begin
          _vram_be  <= 2'b00;
          vram_addr <= disp_addr;
        end
        SEL_MPU: begin
          _vram_be  <= _mpu_be;
          vram_addr <= mpu_addr;
          if (!rd_nxt) begin
            vram_data_out <= mpu_wdata;
          end
        end
        default: begin
          _vram_be <= 2'b11;
        end
      endcase
    end
  end

  // Capture read data on the edge ending a read ACCESS; valid lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_rdata       <= '0;
      disp_rdata_valid <= 1'b0;
      mpu_rdata        <= '0;
      mpu_rdata_valid  <= 1'b0;
    end else begin
      disp_rdata_valid <= cap_disp_s;
      mpu_rdata_valid  <= cap_mpu_s;
      if (cap_disp_s) begin
        disp_rdata <= vram_data_in;
      end
      if (cap_mpu_s) begin
        mpu_rdata <= vram_data_in;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table, hand sequences for starvation and
// reset-abort, then randomized requesters checked against a cycle-kind
// reference model of the arbitration rules.
module tb_vram_arbiter;

  localparam int MAX_RUN = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_ack;
  logic [15:0] disp_rdata;
  logic        disp_rdata_valid;
  logic        mpu_req;
  logic        mpu_wr;
  logic [15:0] mpu_addr;
  logic [1:0]  mpu_be_n;
  logic [15:0] mpu_wdata;
  logic        mpu_ack;
  logic [15:0] mpu_rdata;
  logic        mpu_rdata_valid;
  logic        vram_en_n, vram_rd_n, vram_wr_n;
  logic [1:0]  vram_be_n;
  logic [15:0] vram_addr;
  logic [15:0] vram_data_out;
  logic        vram_data_oe;
  logic [15:0] vram_data_in;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata(disp_rdata), .disp_rdata_valid(disp_rdata_valid),
    .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_addr(mpu_addr), ._mpu_be(mpu_be_n),
    .mpu_wdata(mpu_wdata), .mpu_ack(mpu_ack), .mpu_rdata(mpu_rdata),
    .mpu_rdata_valid(mpu_rdata_valid),
    ._vram_en(vram_en_n), ._vram_rd(vram_rd_n), ._vram_wr(vram_wr_n),
    ._vram_be(vram_be_n), .vram_addr(vram_addr), .vram_data_out(vram_data_out),
    .vram_data_oe(vram_data_oe), .vram_data_in(vram_data_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // ---------------- reference model ----------------
  typedef enum int {K_IDLE, K_DRD, K_MRD, K_MWR, K_TURN} kind_t;

  typedef struct {
    logic dack, mack, en_n, rd_n, wr_n, oe, dval, mval, chk_addr, chk_wdata;
    logic [1:0]  be_n;
    logic [15:0] addr, wdata, drd, mrd;
  } exp_t;

  kind_t       m_prev = K_IDLE;
  int          m_run  = 0;
  logic [15:0] m_drd  = 16'h0000;
  logic [15:0] m_mrd  = 16'h0000;
  exp_t        ex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, ncyc, act, exp);
    end
  endtask

  // Predict what the bus looks like in the cycle after the coming edge.
  task automatic model_step();
    kind_t nk;
    logic  force_m;
    ex = '{dack: 1'b0, mack: 1'b0, en_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, oe: 1'b0,
           dval: 1'b0, mval: 1'b0, chk_addr: 1'b0, chk_wdata: 1'b0, be_n: 2'b11,
           addr: 16'h0000, wdata: 16'h0000, drd: 16'h0000, mrd: 16'h0000};
    if (reset) begin
      m_prev = K_IDLE; m_run = 0; m_drd = 16'h0000; m_mrd = 16'h0000;
      ex.chk_addr = 1'b1; ex.chk_wdata = 1'b1;
    end else begin
      if (m_prev == K_DRD) begin m_drd = vram_data_in; ex.dval = 1'b1; end
      if (m_prev == K_MRD) begin m_mrd = vram_data_in; ex.mval = 1'b1; end
      force_m = GUARD && mpu_req && (m_run >= MAX_RUN);
      if (disp_req && !force_m) nk = K_DRD;
      else if (mpu_req && mpu_wr && (m_prev == K_DRD || m_prev == K_MRD)) nk = K_TURN;
      else if (mpu_req) nk = mpu_wr ? K_MWR : K_MRD;
      else nk = K_IDLE;
      if (!mpu_req || nk == K_MRD || nk == K_MWR) m_run = 0;
      else if (nk == K_DRD) m_run = m_run + 1;
      case (nk)
        K_DRD: begin
          ex.dack = 1'b1; ex.en_n = 1'b0; ex.rd_n = 1'b0; ex.be_n = 2'b00;
          ex.addr = disp_addr; ex.chk_addr = 1'b1;
        end
        K_MRD: begin
          ex.mack = 1'b1; ex.en_n = 1'b0; ex.rd_n = 1'b0; ex.be_n = mpu_be_n;
          ex.addr = mpu_addr; ex.chk_addr = 1'b1;
        end
        K_MWR: begin
          ex.mack = 1'b1; ex.en_n = 1'b0; ex.wr_n = 1'b0; ex.be_n = mpu_be_n; ex.oe = 1'b1;
          ex.addr = mpu_addr; ex.chk_addr = 1'b1; ex.wdata = mpu_wdata; ex.chk_wdata = 1'b1;
        end
        default: ;
      endcase
      m_prev = nk;
    end
    ex.drd = m_drd;
    ex.mrd = m_mrd;
  endtask

  // One clock: predict, step, sample #1 after the edge, compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    chk("disp_ack", 32'(disp_ack), 32'(ex.dack));
    chk("mpu_ack", 32'(mpu_ack), 32'(ex.mack));
    chk("ack_exclusive", 32'(disp_ack & mpu_ack), 32'd0);
    chk("vram_en_n", 32'(vram_en_n), 32'(ex.en_n));
    chk("vram_rd_n", 32'(vram_rd_n), 32'(ex.rd_n));
    chk("vram_wr_n", 32'(vram_wr_n), 32'(ex.wr_n));
    chk("vram_be_n", 32'(vram_be_n), 32'(ex.be_n));
    chk("vram_data_oe", 32'(vram_data_oe), 32'(ex.oe));
    if (ex.chk_addr) chk("vram_addr", 32'(vram_addr), 32'(ex.addr));
    if (ex.chk_wdata) chk("vram_data_out", 32'(vram_data_out), 32'(ex.wdata));
    chk("disp_rdata_valid", 32'(disp_rdata_valid), 32'(ex.dval));
    chk("mpu_rdata_valid", 32'(mpu_rdata_valid), 32'(ex.mval));
    chk("disp_rdata", 32'(disp_rdata), 32'(ex.drd));
    chk("mpu_rdata", 32'(mpu_rdata), 32'(ex.mrd));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst; logic dreq; logic [15:0] daddr;
    logic mreq; logic mwr; logic [1:0] mbe; logic [15:0] maddr; logic [15:0] mwdata; logic [15:0] din;
    logic dack; logic mack; logic en_n; logic rd_n; logic wr_n; logic [1:0] be_n; logic oe; logic [15:0] addr;
    logic dval; logic [15:0] drd; logic mval; logic [15:0] mrd;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_disp;
    int first_mpu;

    // reset; MPU write 0x0123 (REQ-040)
    vecs[0]  = '{1'b1,1'b0,16'h0000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[1]  = '{1'b0,1'b0,16'h0000, 1'b1,1'b1,2'b10,16'h0123,16'hBEEF,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,2'b10,1'b1,16'h0123, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[2]  = '{1'b0,1'b0,16'h0000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000};
    // display read 0x4000 returning 0x1234 (REQ-041)
    vecs[3]  = '{1'b0,1'b1,16'h4000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,16'h4000, 1'b0,16'h0000,1'b0,16'h0000};
    vecs[4]  = '{1'b0,1'b0,16'h0000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h1234, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b1,16'h1234,1'b0,16'h0000};
    // simultaneous display + MPU write: ACCESS, TURN, ACCESS (REQ-042)
    vecs[5]  = '{1'b0,1'b1,16'h0010, 1'b1,1'b1,2'b00,16'h0200,16'hA5A5,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,16'h0010, 1'b0,16'h1234,1'b0,16'h0000};
    vecs[6]  = '{1'b0,1'b0,16'h0000, 1'b1,1'b1,2'b00,16'h0200,16'hA5A5,16'h5678, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b1,16'h5678,1'b0,16'h0000};
    vecs[7]  = '{1'b0,1'b0,16'h0000, 1'b1,1'b1,2'b00,16'h0200,16'hA5A5,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b1,16'h0200, 1'b0,16'h5678,1'b0,16'h0000};
    // write then read back-to-back: no TURN (REQ-045)
    vecs[8]  = '{1'b0,1'b1,16'h0020, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,16'h0020, 1'b0,16'h5678,1'b0,16'h0000};
    vecs[9]  = '{1'b0,1'b0,16'h0000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h9ABC, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b1,16'h9ABC,1'b0,16'h0000};
    // MPU read then MPU write: TURN between them
    vecs[10] = '{1'b0,1'b0,16'h0000, 1'b1,1'b0,2'b01,16'h0444,16'h0000,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b1,2'b01,1'b0,16'h0444, 1'b0,16'h9ABC,1'b0,16'h0000};
    vecs[11] = '{1'b0,1'b0,16'h0000, 1'b1,1'b1,2'b00,16'h0555,16'h7777,16'hCAFE, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b0,16'h9ABC,1'b1,16'hCAFE};
    vecs[12] = '{1'b0,1'b0,16'h0000, 1'b1,1'b1,2'b00,16'h0555,16'h7777,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b1,16'h0555, 1'b0,16'h9ABC,1'b0,16'hCAFE};
    vecs[13] = '{1'b0,1'b0,16'h0000, 1'b0,1'b0,2'b11,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b1,1'b1,2'b11,1'b0,16'h0000, 1'b0,16'h9ABC,1'b0,16'hCAFE};

    reset = 1'b1; disp_req = 1'b0; disp_addr = 16'h0000; mpu_req = 1'b0; mpu_wr = 1'b0;
    mpu_addr = 16'h0000; mpu_be_n = 2'b11; mpu_wdata = 16'h0000; vram_data_in = 16'h0000;
    cycle();
    cycle();

    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst; disp_req = vecs[i].dreq; disp_addr = vecs[i].daddr;
      mpu_req = vecs[i].mreq; mpu_wr = vecs[i].mwr; mpu_be_n = vecs[i].mbe;
      mpu_addr = vecs[i].maddr; mpu_wdata = vecs[i].mwdata; vram_data_in = vecs[i].din;
      cycle();
      chk($sformatf("v%0d_disp_ack", i), 32'(disp_ack), 32'(vecs[i].dack));
      chk($sformatf("v%0d_mpu_ack", i), 32'(mpu_ack), 32'(vecs[i].mack));
      chk($sformatf("v%0d_en_n", i), 32'(vram_en_n), 32'(vecs[i].en_n));
      chk($sformatf("v%0d_rd_n", i), 32'(vram_rd_n), 32'(vecs[i].rd_n));
      chk($sformatf("v%0d_wr_n", i), 32'(vram_wr_n), 32'(vecs[i].wr_n));
      chk($sformatf("v%0d_be_n", i), 32'(vram_be_n), 32'(vecs[i].be_n));
      chk($sformatf("v%0d_oe", i), 32'(vram_data_oe), 32'(vecs[i].oe));
      chk($sformatf("v%0d_dval", i), 32'(disp_rdata_valid), 32'(vecs[i].dval));
      chk($sformatf("v%0d_drd", i), 32'(disp_rdata), 32'(vecs[i].drd));
      chk($sformatf("v%0d_mval", i), 32'(mpu_rdata_valid), 32'(vecs[i].mval));
      chk($sformatf("v%0d_mrd", i), 32'(mpu_rdata), 32'(vecs[i].mrd));
      if (vecs[i].rst || !vecs[i].en_n)
        chk($sformatf("v%0d_addr", i), 32'(vram_addr), 32'(vecs[i].addr));
      if (vecs[i].rst)
        chk($sformatf("v%0d_wdata", i), 32'(vram_data_out), 32'd0);
      else if (vecs[i].oe)
        chk($sformatf("v%0d_wdata", i), 32'(vram_data_out), 32'(vecs[i].mwdata));
    end

    // Display held for 20 cycles with an MPU read waiting (REQ-043)
    disp_req = 1'b1; disp_addr = 16'h0800;
    mpu_req = 1'b1; mpu_wr = 1'b0; mpu_addr = 16'h0900; mpu_be_n = 2'b00;
    n_disp = 0; first_mpu = -1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (mpu_ack && first_mpu < 0) first_mpu = n_disp;
      if (disp_ack) n_disp++;
      if (mpu_ack) mpu_req = 1'b0;
    end
    disp_req = 1'b0;
    if (GUARD) begin
      chk("starve_guard_disp_run", 32'(first_mpu), 32'(MAX_RUN));
      cycle();
    end else begin
      chk("strict_prio_mpu_waits", 32'(first_mpu), 32'hFFFF_FFFF);
      chk("strict_prio_disp_grants", 32'(n_disp), 32'd20);
      cycle();
      chk("mpu_after_disp_drop", 32'(mpu_ack), 32'd1);
      mpu_req = 1'b0;
      cycle();
    end

    // Reset asserted during a display read ACCESS (REQ-044)
    disp_req = 1'b1; disp_addr = 16'h1230;
    cycle();
    chk("abort_setup_ack", 32'(disp_ack), 32'd1);
    disp_req = 1'b0; reset = 1'b1; vram_data_in = 16'hDEAD;
    cycle();
    chk("abort_en_high", 32'(vram_en_n), 32'd1);
    chk("abort_rd_high", 32'(vram_rd_n), 32'd1);
    chk("abort_no_valid", 32'(disp_rdata_valid), 32'd0);
    reset = 1'b0;
    cycle();
    chk("abort_no_valid_after", 32'(disp_rdata_valid), 32'd0);
    chk("abort_rdata_cleared", 32'(disp_rdata), 32'd0);

    // Randomized requesters that hold until ack, checked by the model
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(99, 0) == 0);
      vram_data_in = 16'($urandom);
      cycle();
      if (disp_ack) begin
        if ($urandom_range(1, 0) == 1) disp_addr = 16'($urandom);
        else disp_req = 1'b0;
      end else if (!disp_req && $urandom_range(2, 0) == 0) begin
        disp_req = 1'b1; disp_addr = 16'($urandom);
      end
      if (mpu_ack || (!mpu_req && $urandom_range(1, 0) == 0)) begin
        mpu_req   = (mpu_ack) ? ($urandom_range(1, 0) == 1) : 1'b1;
        mpu_wr    = 1'($urandom_range(1, 0));
        mpu_addr  = 16'($urandom);
        mpu_be_n  = 2'($urandom_range(3, 0));
        mpu_wdata = 16'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
